// File: rtl/nested_fsm_sched_pkg.sv
// nested_fsm_sched_pkg: state encoding and default sizing shared by the nested scheduler files.
// Package nested_sched_pkg, no ports.
package nested_sched_pkg;
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN_A = 2'b01;
  localparam logic [1:0] S_RUN_B = 2'b10;
  localparam int PASSES_DEF  = 2;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/nested_fsm_sched_if.sv
// nested_fsm_sched_if: control/status bundle between the parent scheduler and its driver.
// Ports: none. Signals: start, abort, done_a, done_b (to scheduler); hold_a, hold_b, busy,
// match, timeout_err, pass_cnt[CNT_W] (from scheduler). master = driver side, slave = scheduler.
interface nested_fsm_sched_if #(
  parameter int CNT_W = 2
);
  logic start;
  logic abort;
  logic done_a;
  logic done_b;
  logic hold_a;
  logic hold_b;
  logic busy;
  logic match;
  logic timeout_err;
  logic [CNT_W-1:0] pass_cnt;
  modport master (
    output start, abort, done_a, done_b,
    input  hold_a, hold_b, busy, match, timeout_err, pass_cnt
  );
  modport slave (
    input  start, abort, done_a, done_b,
    output hold_a, hold_b, busy, match, timeout_err, pass_cnt
  );
endinterface

// File: rtl/nested_fsm_sched_wdt.sv
// sched_wdt: cycle counter for the active child state; expires at TIMEOUT-1.
// Ports: clk, rst (sync, active-high), i_clr (state change), i_run (a child is active),
// o_expire (timer has reached TIMEOUT-1). Built only with NESTED_FSM_SCHED_WDT_EN.
module sched_wdt
  import nested_sched_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expire
);
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] r_timer;
  assign o_expire = r_timer == TW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst || i_clr || !i_run) r_timer <= '0;
    else r_timer <= r_timer + 1'b1;
  end
endmodule

// File: rtl/nested_fsm_sched.sv
// nested_fsm_sched: parent FSM that releases child detector A then B and counts A->B passes.
// Ports: clk, rst (sync, active-high), bus (nested_fsm_sched_if.slave): start, abort, done_a,
// done_b in; hold_a, hold_b, busy, match, timeout_err, pass_cnt out (all registered).
// Macro NESTED_FSM_SCHED_WDT_EN adds the per-state watchdog; otherwise timeout_err stays 0.
module nested_fsm_sched
  import nested_sched_pkg::*;
#(
  parameter int PASSES  = PASSES_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clk,
  input logic rst,
  nested_fsm_sched_if.slave bus
);
  localparam int CNT_W = $clog2(PASSES + 1);
  if (PASSES < 1 || TIMEOUT < 2) begin : g_bad_cfg
    $error("nested_fsm_sched: needs PASSES >= 1 and TIMEOUT >= 2");
  end
  logic [1:0] r_state, w_next;
  logic r_hold_a, r_hold_b, r_busy, r_match, r_terr;
  logic [CNT_W-1:0] r_pass_cnt;
  logic w_run, w_done, w_last, w_expire, w_bump;
  assign w_run  = r_state == S_RUN_A || r_state == S_RUN_B;
  assign w_done = (r_state == S_RUN_A && bus.done_a) || (r_state == S_RUN_B && bus.done_b);
  assign w_last = r_state == S_RUN_B && r_pass_cnt + 1'b1 == CNT_W'(PASSES);
  assign w_bump = w_run && !bus.abort && w_done && r_state == S_RUN_B && r_pass_cnt != CNT_W'(PASSES);
`ifdef NESTED_FSM_SCHED_WDT_EN
  sched_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_next != r_state),
    .i_run    (w_run),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif
  // abort outranks the active done, which outranks watchdog expiry
  always_comb begin
    w_next = !w_run ? (bus.start ? S_RUN_A : S_IDLE)
           : bus.abort ? S_IDLE
           : w_done ? (r_state == S_RUN_A ? S_RUN_B : (w_last ? S_IDLE : S_RUN_A))
           : w_expire ? S_IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hold_a   <= 1'b1;
      r_hold_b   <= 1'b1;
      r_busy     <= 1'b0;
      r_match    <= 1'b0;
      r_terr     <= 1'b0;
      r_pass_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_hold_a   <= w_next != S_RUN_A;
      r_hold_b   <= w_next != S_RUN_B;
      r_busy     <= w_next != S_IDLE;
      r_match    <= w_run && !bus.abort && w_done && w_last;
      r_terr     <= w_run && !bus.abort && !w_done && w_expire;
      r_pass_cnt <= (!w_run && bus.start) ? '0 : w_bump ? r_pass_cnt + 1'b1 : r_pass_cnt;
    end
  end
  assign bus.hold_a      = r_hold_a;
  assign bus.hold_b      = r_hold_b;
  assign bus.busy        = r_busy;
  assign bus.match       = r_match;
  assign bus.timeout_err = r_terr;
  assign bus.pass_cnt    = r_pass_cnt;
endmodule
